ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage for the 8-bit accumulator CPU. It holds the program counter and drives the address of the combinational instruction memory. It captures the returned 8-bit word into a one-entry instruction register and hands it to the decode/control unit over a valid/ready handshake. It also applies redirects from jump/branch execution and stops fetching on the stop instruction or on an out-of-range program counter.

## Interface
- `RESET_PC`, default 0: program counter value after reset.
- `MEM_DEPTH`, default 10: number of valid instruction memory words. Addresses at or above this value are out of range.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `ad` output 8: instruction memory address. Combinational copy of `pc`.
- `ins` input 8: instruction memory read data. Valid in the same cycle as `ad`.
- `ir` output 8: instruction register presented to decode.
- `ir_valid` output 1: `ir` holds an undelivered instruction.
- `ir_ready` input 1: decode accepts `ir` this cycle.
- `redir` input 1: redirect request from execute (jmp/ban taken).
- `redir_ad` input 8: redirect target address.
- `pc` output 8: current fetch address.
- `halted` output 1: fetch has stopped (HALT or FAULT).
- `fault` output 1: fetch stopped on an out-of-range address.

## Operation
- States:
  - RUN: fetching.
  - HALT: stop word captured.
  - FAULT: out-of-range fetch attempted.
- Outputs by state:
  - `halted` = 1 in HALT and FAULT.
  - `fault` = 1 only in FAULT.
  - Both are registered state decodes.
- The stop word is {`cu_long_begin`, `cu_stop`}.
- Slot free: `slot_free` = !`ir_valid` || `ir_ready`.
- Capture happens when state is RUN, `redir` = 0, `slot_free`, and `pc` < `MEM_DEPTH`. On capture:
  - `ir` <= `ins`, `ir_valid` <= 1.
  - If `ins` is the stop word: `pc` holds and state goes to HALT.
  - Otherwise `pc` <= `pc` + 1, modulo 256.
- Delivery without capture: if `ir_valid` && `ir_ready` and no capture, then `ir_valid` <= 0. `ir` keeps its old value.
- Redirect, in RUN with `redir` = 1:
  - `pc` <= `redir_ad`, `ir_valid` <= 0 (flush), no capture that cycle.
  - Redirect takes priority over both capture and delivery.
- Fault: in RUN with `redir` = 0, `slot_free`, and `pc` >= `MEM_DEPTH`:
  - State goes to FAULT and no capture happens.
  - `pc` holds. `ir_valid` follows the delivery rule.
- HALT and FAULT:
  - `redir` is ignored.
  - A pending `ir` is still delivered, so the stop word reaches decode.
  - `pc` is frozen.
  - Only `rst` leaves these states.
- Backpressure: while `ir_valid` && !`ir_ready`, `ir` and `pc` hold and nothing is captured.
- Upper bits of `ins` are not range-checked. Decode interprets the 3-bit opcode and 5-bit field.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, `ad` = `RESET_PC`.
  - `ir` = 0, `ir_valid` = 0.
  - State RUN, so `halted` = 0 and `fault` = 0.
- `rst` overrides every other input in the same edge, including mid-handshake and mid-redirect.
- Latency:
  - Address to `ir`: 1 cycle.
  - Redirect to first new `ir_valid`: 2 cycles (flush cycle, then capture).
- Throughput: 1 instruction per cycle with `ir_ready` held high.
- `halted` rises on the edge that captures the stop word, i.e. in the same cycle `ir_valid` presents it.
- `ad` has no register stage; the memory read is combinational.

## Structure
- Opcode macros (`cu_*`, `cu_long_begin`, `cu_stop`) come from the shared `define.v`.
- State encodings (RUN=2'd0, HALT=2'd1, FAULT=2'd2) are added to `define.v` as `if_*` macros.
- Single module with no sub-modules. The one-entry IR buffer is inline.
- Top-level wiring:
  - `ifetch.ad` connects to `imem.ad`.
  - `imem.out` connects to `ifetch.ins`.

## Test plan
- Reset, then `ir_ready`=1 held, with the standard 9-word program:
  - `ir` sequence is words 0..8 on cycles 1..9.
  - `halted`=1 from cycle 9, `pc`=8 frozen, `fault`=0.
- Backpressure:
  - After the first capture, `ir_ready`=0 for 3 cycles: `ir`=word0, `ir_valid`=1, `pc`=1 held.
  - Release: word1 appears on the next cycle.
- Redirect:
  - `redir`=1, `redir_ad`=7 while `ir_valid`=1 and `ir_ready`=0.
  - Next cycle: `ir_valid`=0, `pc`=7.
  - Cycle after: `ir`={`cu_long_begin`,`cu_cla`}, `pc`=8.
- Out of range:
  - Redirect to `redir_ad`=10 with `MEM_DEPTH`=10.
  - Two cycles later: `fault`=1, `halted`=1, `ir_valid`=0, `pc`=10.
  - Further redirects are ignored.
- Halted ignores redirect:
  - In HALT, `redir`=1 with `redir_ad`=0: `pc` stays 8, `halted` stays 1.
  - The stop word is delivered once when `ir_ready`=1.
- Reset mid-run:
  - `rst`=1 at cycle 4 with `ir_valid`=1.
  - Next cycle: `pc`=0, `ir`=0, `ir_valid`=0, `halted`=0, `fault`=0.
  - Refetch starts at word0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared opcode fields and fetch-state encodings for the 8-bit accumulator CPU.
// An instruction word is a 3-bit opcode followed by a 5-bit field.
package ifetch_pkg;

  localparam logic [2:0] CU_LONG_BEGIN = 3'b111;
  localparam logic [4:0] CU_STOP       = 5'h1f;
  localparam logic [4:0] CU_CLA        = 5'h00;

  localparam logic [7:0] STOP_WORD = {CU_LONG_BEGIN, CU_STOP};

  localparam logic [1:0] IF_RUN   = 2'd0;
  localparam logic [1:0] IF_HALT  = 2'd1;
  localparam logic [1:0] IF_FAULT = 2'd2;

  function automatic logic is_stop(input logic [7:0] word);
    return word == STOP_WORD;
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: program counter, one-entry instruction register with a
// valid/ready handshake to decode, redirects from execute, stop/fault handling.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC  = 8'd0,
  parameter int         MEM_DEPTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] ad,
  input  logic [7:0] ins,
  output logic [7:0] ir,
  output logic       ir_valid,
  input  logic       ir_ready,
  input  logic       redir,
  input  logic [7:0] redir_ad,
  output logic [7:0] pc,
  output logic       halted,
  output logic       fault
);

  logic [1:0] state;
  logic       run;
  logic       slot_free;
  logic       in_range;
  logic       capture;
  logic       deliver;

  assign ad        = pc;
  assign run       = (state == IF_RUN);
  assign slot_free = !ir_valid || ir_ready;
  assign in_range  = int'({24'd0, pc}) < MEM_DEPTH;
  assign capture   = run && !redir && slot_free && in_range;
  assign deliver   = ir_valid && ir_ready;

  // halted/fault are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= 8'd0;
      ir_valid <= 1'b0;
      state    <= IF_RUN;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else if (run && redir) begin
      pc       <= redir_ad;
      ir_valid <= 1'b0;
    end else if (capture) begin
      ir       <= ins;
      ir_valid <= 1'b1;
      if (is_stop(ins)) begin
        state  <= IF_HALT;
        halted <= 1'b1;
      end else begin
        pc <= pc + 8'd1;
      end
    end else begin
      if (deliver) ir_valid <= 1'b0;
      // Reaching here in RUN with a free slot means pc is out of range.
      if (run && slot_free) begin
        state  <= IF_FAULT;
        halted <= 1'b1;
        fault  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized and directed bench for ifetch against a cycle-level reference model.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ad;
  logic [7:0] ins;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic       redir = 1'b0;
  logic [7:0] redir_ad = 8'd0;
  logic [7:0] pc;
  logic       halted;
  logic       fault;

  logic [7:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = fetching, 1 = stopped on stop word, 2 = stopped on bad address
  int       m_pc;
  int       m_ir;
  bit       m_vld;
  int       m_mode;

  ifetch #(.RESET_PC(8'd0), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ad(ad), .ins(ins), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .redir(redir), .redir_ad(redir_ad), .pc(pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign ins = (int'(ad) < DEPTH) ? mem[ad] : 8'h5a;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit free;
    if (rst) begin
      m_pc = 0; m_ir = 0; m_vld = 0; m_mode = 0;
      return;
    end
    free = !m_vld || ir_ready;
    if (m_mode == 0 && redir) begin
      m_pc  = int'(redir_ad);
      m_vld = 0;
    end else if (m_mode == 0 && free && m_pc < DEPTH) begin
      m_ir  = int'(mem[m_pc]);
      m_vld = 1;
      if (mem[m_pc] == STOP_WORD) m_mode = 1;
      else m_pc = (m_pc + 1) % 256;
    end else begin
      if (m_mode == 0 && free) m_mode = 2;
      if (m_vld && ir_ready) m_vld = 0;
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, 8'(m_pc));
    check("ad", ad, 8'(m_pc));
    check("ir", ir, 8'(m_ir));
    check("ir_valid", {7'd0, ir_valid}, {7'd0, m_vld});
    check("halted", {7'd0, halted}, {7'd0, m_mode != 0});
    check("fault", {7'd0, fault}, {7'd0, m_mode == 2});
  endtask

  task automatic do_reset();
    rst = 1'b1; redir = 1'b0; ir_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      do mem[i] = 8'($urandom); while (mem[i] == STOP_WORD);
    end
    mem[7] = {CU_LONG_BEGIN, CU_CLA};
    mem[8] = STOP_WORD;

    // Reset values
    do_reset();
    check("rst_pc", pc, 8'd0);
    check("rst_ir", ir, 8'd0);
    check("rst_vld", {7'd0, ir_valid}, 8'd0);
    check("rst_halted", {7'd0, halted}, 8'd0);
    check("rst_fault", {7'd0, fault}, 8'd0);

    // Straight-line run through the stop word
    ir_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("seq_ir", ir, mem[k-1]);
      check("seq_halted", {7'd0, halted}, {7'd0, k == 9});
    end
    check("halt_pc", pc, 8'd8);
    check("halt_fault", {7'd0, fault}, 8'd0);

    // Redirect ignored while halted; stop word delivered exactly once
    ir_ready = 1'b0; redir = 1'b1; redir_ad = 8'd0;
    step();
    check("halt_redir_pc", pc, 8'd8);
    check("halt_redir_halted", {7'd0, halted}, 8'd1);
    check("halt_redir_vld", {7'd0, ir_valid}, 8'd1);
    redir = 1'b0; ir_ready = 1'b1;
    step();
    check("stop_delivered", {7'd0, ir_valid}, 8'd0);
    step();
    check("stop_once", {7'd0, ir_valid}, 8'd0);
    check("halt_pc_frozen", pc, 8'd8);

    // Backpressure
    do_reset();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ir", ir, mem[0]);
      check("bp_vld", {7'd0, ir_valid}, 8'd1);
      check("bp_pc", pc, 8'd1);
    end
    ir_ready = 1'b1;
    step();
    check("bp_release", ir, mem[1]);

    // Redirect during backpressure
    ir_ready = 1'b0; redir = 1'b1; redir_ad = 8'd7;
    step();
    check("redir_vld", {7'd0, ir_valid}, 8'd0);
    check("redir_pc", pc, 8'd7);
    redir = 1'b0; ir_ready = 1'b1;
    step();
    check("redir_ir", ir, {CU_LONG_BEGIN, CU_CLA});
    check("redir_pc2", pc, 8'd8);

    // Out-of-range fetch
    do_reset();
    ir_ready = 1'b1;
    step();
    redir = 1'b1; redir_ad = 8'd10;
    step();
    redir = 1'b0;
    step();
    check("oor_fault", {7'd0, fault}, 8'd1);
    check("oor_halted", {7'd0, halted}, 8'd1);
    check("oor_vld", {7'd0, ir_valid}, 8'd0);
    check("oor_pc", pc, 8'd10);
    redir = 1'b1; redir_ad = 8'd3;
    step();
    check("oor_redir_pc", pc, 8'd10);
    check("oor_redir_fault", {7'd0, fault}, 8'd1);
    redir = 1'b0;

    // Reset mid-run
    do_reset();
    ir_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    ir_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_pc", pc, 8'd0);
    check("mid_rst_ir", ir, 8'd0);
    check("mid_rst_vld", {7'd0, ir_valid}, 8'd0);
    check("mid_rst_halted", {7'd0, halted}, 8'd0);
    ir_ready = 1'b1;
    step();
    check("mid_rst_refetch", ir, mem[0]);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 79) == 0);
      redir    = ($urandom_range(0, 7) == 0);
      redir_ad = 8'($urandom_range(0, 12));
      ir_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
